// File: rtl/clockworks_gearbox_pkg.sv
// clockworks_gearbox_pkg: shared defaults for the clock gearbox and reset conditioner
package clockworks_gearbox_pkg;
  localparam int SLOW_DEFAULT = 21;
  localparam int RST_CYCLES_DEFAULT = 4;
  localparam int RC_W = 4;
endpackage

// File: rtl/clockworks_gearbox_if.sv
// clockworks_gearbox_if: core clock and core reset as seen by the SOC core
interface clockworks_gearbox_if;
  logic clk;
  logic resetn;
  modport master (output clk, output resetn);
  modport slave (input clk, input resetn);
endinterface

// File: rtl/clockworks_reset_sync.sv
// clockworks_reset_sync: async-assert, sync-release reset stretcher on the core clock
module clockworks_reset_sync
  import clockworks_gearbox_pkg::*;
#(
  parameter int RST_CYCLES = RST_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic RESET,
  output logic resetn
);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(RST_CYCLES);
  logic s1, s2;
  logic [RC_W-1:0] rc, rc_next;
  assign rc_next = (s2 && rc != RC_MAX) ? rc + 1'b1 : rc;
  // synchronize RESET release, then hold resetn low until the stretch count completes
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      rc <= '0;
      resetn <= 1'b0;
    end else begin
      s1 <= 1'b1;
      s2 <= s1;
      rc <= rc_next;
      resetn <= rc_next == RC_MAX;
    end
  end
endmodule

// File: rtl/clockworks_gearbox.sv
// clockworks_gearbox: divides the board clock by 2^SLOW and conditions the core reset
module clockworks_gearbox
  import clockworks_gearbox_pkg::*;
#(
  parameter int SLOW = SLOW_DEFAULT,
  parameter int RST_CYCLES = RST_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  clockworks_gearbox_if.master core
);
  logic clk;
  generate
    if (SLOW == 0) begin : g_fast
      assign clk = CLK;
    end else begin : g_div
      logic [SLOW-1:0] cnt;
      // free-running divider; its MSB is a 50% duty core clock
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) cnt <= '0;
        else cnt <= cnt + 1'b1;
      end
      assign clk = cnt[SLOW-1];
    end
  endgenerate
  assign core.clk = clk;
  clockworks_reset_sync #(.RST_CYCLES(RST_CYCLES)) u_reset_sync (
    .clk(clk),
    .RESET(RESET),
    .resetn(core.resetn)
  );
endmodule

// File: tb/tb_clockworks_gearbox.sv
// tb_clockworks_gearbox: divided and undivided gearbox builds driven from one board clock
module tb_clockworks_gearbox;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  clockworks_gearbox_if gs ();
  clockworks_gearbox_if gf ();
  clockworks_gearbox #(.SLOW(3), .RST_CYCLES(4)) dut_s (.CLK(CLK), .RESET(RESET), .core(gs));
  clockworks_gearbox #(.SLOW(0), .RST_CYCLES(4)) dut_f (.CLK(CLK), .RESET(RESET), .core(gf));
  always #5 CLK = ~CLK;
  typedef struct {
    int off;
    int low;
    int bounces;
    int exp_rise;
    int exp_edges;
  } vec_t;
  vec_t tbl[5];
  int total = 0;
  int bad = 0;
  int exp_q[$];
  int expf_q[$];
  int nc, ns, nf;
  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask
  task automatic count_slow(output int n);
    n = 0;
    while (n < 60) begin
      @(posedge gs.clk);
      #1;
      n++;
      if (gs.resetn === 1'b1) break;
    end
  endtask
  task automatic count_fast(output int n);
    n = 0;
    while (n < 60) begin
      @(posedge gf.clk);
      #1;
      n++;
      if (gf.resetn === 1'b1) break;
    end
  endtask
  task automatic first_rise(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge CLK);
      #1;
      n++;
      if (gs.clk === 1'b1) break;
    end
  endtask
  task automatic release_seq(input string tag, input int exp_rise, input int exp_edges);
    exp_q.push_back(exp_edges);
    expf_q.push_back(exp_edges);
    fork
      first_rise(nc);
      count_slow(ns);
      count_fast(nf);
    join
    check({tag, " first_clk_rise"}, nc, exp_rise);
    check({tag, " slow_release_edges"}, ns, exp_q.pop_front());
    check({tag, " fast_release_edges"}, nf, expf_q.pop_front());
  endtask
  initial begin
    int t0, t1, t2, rises, drops, trk;
    logic prev;
    tbl[0] = '{off: 1, low: 3,  bounces: 0, exp_rise: 4, exp_edges: 6};
    tbl[1] = '{off: 3, low: 20, bounces: 0, exp_rise: 4, exp_edges: 6};
    tbl[2] = '{off: 1, low: 57, bounces: 0, exp_rise: 4, exp_edges: 6};
    tbl[3] = '{off: 2, low: 4,  bounces: 3, exp_rise: 4, exp_edges: 6};
    tbl[4] = '{off: 2, low: 2,  bounces: 0, exp_rise: 4, exp_edges: 6};
    #1;
    check("pwr slow_resetn", int'(gs.resetn), 0);
    check("pwr fast_resetn", int'(gf.resetn), 0);
    check("pwr slow_clk", int'(gs.clk), 0);
    release_seq("pwr", 4, 6);
    @(posedge gs.clk);
    t0 = int'($time);
    @(negedge gs.clk);
    t1 = int'($time);
    @(posedge gs.clk);
    t2 = int'($time);
    check("clk_high_time", t1 - t0, 40);
    check("clk_low_time", t2 - t1, 40);
    check("clk_period", t2 - t0, 80);
    foreach (tbl[i]) begin
      @(negedge CLK);
      #(tbl[i].off);
      repeat (tbl[i].bounces) begin
        RESET = 1'b0;
        #(tbl[i].low);
        RESET = 1'b1;
        #8;
      end
      RESET = 1'b0;
      #1;
      check($sformatf("v%0d pulse slow_resetn", i), int'(gs.resetn), 0);
      check($sformatf("v%0d pulse fast_resetn", i), int'(gf.resetn), 0);
      check($sformatf("v%0d pulse slow_clk", i), int'(gs.clk), 0);
      #(tbl[i].low - 1);
      RESET = 1'b1;
      release_seq($sformatf("v%0d", i), tbl[i].exp_rise, tbl[i].exp_edges);
    end
    rises = 0;
    drops = 0;
    trk = 0;
    @(negedge CLK);
    prev = gs.clk;
    repeat (800) begin
      @(posedge CLK);
      #1;
      if (gs.clk === 1'b1 && prev === 1'b0) rises++;
      if (gs.resetn !== 1'b1 || gf.resetn !== 1'b1) drops++;
      if (gf.clk !== 1'b1) trk++;
      prev = gs.clk;
      @(negedge CLK);
      #1;
      if (gf.clk !== 1'b0) trk++;
    end
    check("long_run clk_rises", rises, 100);
    check("long_run resetn_drops", drops, 0);
    check("fast_clk_tracks_CLK", trk, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
